id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage RV32I core: it registers the decoded instruction from ID and feeds the ALU its `alu_ctrl`, `src1` and `src2` operands. It resolves data hazards by forwarding from MEM and WB, and flags load-use hazards back to the hazard unit. It accepts stall and flush controls, and it preserves forwarded operands across a stall.

---
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RV32I core: holds the decoded instruction,
// forwards MEM/WB results into the ALU operands and flags load-use hazards.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [3:0]  id_alu_ctrl,
  input  logic        id_use_pc,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_result,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_store_data,
  output logic        load_use_hazard
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_ctrl;
    logic        use_pc;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
  } ex_reg_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // An all-zero record is the bubble: no write, no load, ADD, x0 everywhere.
  localparam ex_reg_t BUBBLE = '0;

  ex_reg_t     ex_q;
  ex_reg_t     ex_d;
  fwd_sel_t    fwd1_sel;
  fwd_sel_t    fwd2_sel;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // The youngest producer (MEM) wins; x0 is hard-wired and never forwarded.
  function automatic fwd_sel_t select_source(
    input logic [4:0] rs,
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd
  );
    fwd_sel_t sel;
    sel = FWD_REG;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  function automatic logic [31:0] pick(
    input fwd_sel_t    sel,
    input logic [31:0] held,
    input logic [31:0] mem_val,
    input logic [31:0] wb_val
  );
    logic [31:0] val;
    unique case (sel)
      FWD_MEM: val = mem_val;
      FWD_WB:  val = wb_val;
      default: val = held;
    endcase
    return val;
  endfunction

  always_comb begin
    fwd1_sel = select_source(ex_q.rs1_addr, mem_reg_write, mem_rd_addr,
                             wb_reg_write, wb_rd_addr);
    fwd2_sel = select_source(ex_q.rs2_addr, mem_reg_write, mem_rd_addr,
                             wb_reg_write, wb_rd_addr);
    fwd_rs1  = pick(fwd1_sel, ex_q.rs1_data, mem_result, wb_result);
    fwd_rs2  = pick(fwd2_sel, ex_q.rs2_data, mem_result, wb_result);
  end

  // The rs2 index is compared even for instructions that ignore rs2; a spurious
  // stall is harmless, a missed one is not.
  assign load_use_hazard = id_valid && ex_q.valid && ex_q.mem_read &&
                           (ex_q.rd_addr != 5'd0) &&
                           ((id_rs1_addr == ex_q.rd_addr) ||
                            (id_rs2_addr == ex_q.rd_addr));

  always_comb begin
    // NOTE: ex_d takes a full default first so no path through this block infers a latch.
    ex_d = ex_q;
    if (flush) begin
      ex_d = BUBBLE;
    end else if (stall) begin
      // Capture forwarded operands now; their producers may retire during the stall.
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (load_use_hazard || !id_valid) begin
      ex_d = BUBBLE;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = id_pc;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
      ex_d.rs1_addr  = id_rs1_addr;
      ex_d.rs2_addr  = id_rs2_addr;
      ex_d.rd_addr   = id_rd_addr;
      ex_d.alu_ctrl  = id_alu_ctrl;
      ex_d.use_pc    = id_use_pc;
      ex_d.use_imm   = id_use_imm;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= BUBBLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      ex_q <= ex_d;
    end
  end

  assign alu_ctrl      = ex_q.alu_ctrl;
  assign src1          = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign src2          = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_rd_addr    = ex_q.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed corner sequences, a forwarding
// vector table and randomized cycles checked against an instruction-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_use_pc, id_use_imm, id_reg_write, id_mem_read;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;
  logic        stall, flush;
  logic [3:0]  alu_ctrl;
  logic [31:0] src1, src2, ex_store_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
  logic [4:0]  ex_rd_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .stall(stall), .flush(flush),
    .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  // Model: the instruction currently sitting in EX, as ID presented it.
  typedef struct packed {
    bit        valid;
    bit [31:0] pc, a, b, imm;
    bit [4:0]  ra, rb, rd;
    bit [3:0]  op;
    bit        upc, uimm, we, ld;
  } instr_t;

  instr_t m;

  typedef struct {
    bit        mem_we;
    bit [4:0]  mem_rd;
    bit [31:0] mem_res;
    bit        wb_we;
    bit [4:0]  wb_rd;
    bit [31:0] wb_res;
    bit [31:0] exp_src1, exp_src2, exp_store;
  } fwd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] held);
    if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == r) return mem_result;
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == r) return wb_result;
    return held;
  endfunction

  function automatic bit hazard_exp();
    return id_valid && m.valid && m.ld && m.rd != 0 &&
           (id_rs1_addr == m.rd || id_rs2_addr == m.rd);
  endfunction

  function automatic instr_t next_exp();
    instr_t n;
    n = m;
    if (!rst || flush) return '0;
    if (stall) begin
      n.a = operand(m.ra, m.a);
      n.b = operand(m.rb, m.b);
      return n;
    end
    if (hazard_exp() || !id_valid) return '0;
    n = '{valid: 1'b1, pc: id_pc, a: id_rs1_data, b: id_rs2_data, imm: id_imm,
          ra: id_rs1_addr, rb: id_rs2_addr, rd: id_rd_addr, op: id_alu_ctrl,
          upc: id_use_pc, uimm: id_use_imm, we: id_reg_write, ld: id_mem_read};
    return n;
  endfunction

  // Advance one edge; leaves the caller 1 time unit after the rising edge.
  task automatic tick();
    instr_t n;
    n = next_exp();
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic check_all(input string tag);
    #2;
    check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m.op));
    check({tag, ".src1"}, src1, m.upc ? m.pc : operand(m.ra, m.a));
    check({tag, ".src2"}, src2, m.uimm ? m.imm : operand(m.rb, m.b));
    check({tag, ".store"}, ex_store_data, operand(m.rb, m.b));
    check({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
    check({tag, ".reg_write"}, 32'(ex_reg_write), 32'(m.we));
    check({tag, ".mem_read"}, 32'(ex_mem_read), 32'(m.ld));
    check({tag, ".rd"}, 32'(ex_rd_addr), 32'(m.rd));
    check({tag, ".hazard"}, 32'(load_use_hazard), 32'(hazard_exp()));
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, r1d, r2d, imm,
                        input logic [4:0] ra, rb, rd, input logic [3:0] op,
                        input logic upc, uimm, we, ld);
    id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1_addr = ra; id_rs2_addr = rb; id_rd_addr = rd; id_alu_ctrl = op;
    id_use_pc = upc; id_use_imm = uimm; id_reg_write = we; id_mem_read = ld;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 1'b0; mem_rd_addr = 5'd0; mem_result = '0;
    wb_reg_write  = 1'b0; wb_rd_addr  = 5'd0; wb_result  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_vec_t vecs[7];
    m = '0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_fwd();

    // EX holds rs1=x5 (0x111), rs2=x6 (0x222) while MEM/WB vary.
    vecs[0] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        32'h111,      32'h222,   32'h222};
    vecs[1] = '{1, 5'd5, 32'h0000AAAA, 1, 5'd5, 32'h00005555, 32'h0000AAAA, 32'h222,   32'h222};
    vecs[2] = '{0, 5'd5, 32'h0000AAAA, 1, 5'd5, 32'h00005555, 32'h00005555, 32'h222,   32'h222};
    vecs[3] = '{1, 5'd6, 32'hBBBB,     1, 5'd5, 32'hCCCC,     32'hCCCC,     32'hBBBB,  32'hBBBB};
    vecs[4] = '{1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hEEEE,     32'h111,      32'h222,   32'h222};
    vecs[5] = '{1, 5'd7, 32'h7777,     0, 5'd6, 32'hDDDD,     32'h111,      32'h222,   32'h222};
    vecs[6] = '{1, 5'd5, 32'h1,        1, 5'd6, 32'h2,        32'h1,        32'h2,     32'h2};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset.valid", 32'(ex_valid), 32'd0);
    check("reset.alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("reset.src1", src1, 32'd0);
    check("reset.src2", src2, 32'd0);
    check("reset.rd", 32'(ex_rd_addr), 32'd0);
    check("reset.hazard", 32'(load_use_hazard), 32'd0);
    rst = 1'b1;

    // MEM forward into rs1=x3
    set_id(1'b1, 32'h40, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h10;
    #2;
    check("mem_fwd.src1", src1, 32'h10);
    check("mem_fwd.valid", 32'(ex_valid), 32'd1);
    clear_fwd();

    // x0 is never forwarded
    set_id(1'b1, 32'h44, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hFFFFFFFF;
    #2;
    check("x0_guard.src2", src2, 32'h0);
    check("x0_guard.store", ex_store_data, 32'h0);
    clear_fwd();

    // Forwarding priority table
    set_id(1'b1, 32'h48, 32'h111, 32'h222, 32'h0, 5'd5, 5'd6, 5'd10, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_reg_write = vecs[i].mem_we; mem_rd_addr = vecs[i].mem_rd; mem_result = vecs[i].mem_res;
      wb_reg_write  = vecs[i].wb_we;  wb_rd_addr  = vecs[i].wb_rd;  wb_result  = vecs[i].wb_res;
      #1;
      check($sformatf("fwd_tab[%0d].src1", i), src1, vecs[i].exp_src1);
      check($sformatf("fwd_tab[%0d].src2", i), src2, vecs[i].exp_src2);
      check($sformatf("fwd_tab[%0d].store", i), ex_store_data, vecs[i].exp_store);
    end
    clear_fwd();

    // use_pc / use_imm selects; store data still forwarded
    set_id(1'b1, 32'h100, 32'h1, 32'h2, 32'h44, 5'd1, 5'd6, 5'd3, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd6; mem_result = 32'h99;
    #2;
    check("sel.src1_pc", src1, 32'h100);
    check("sel.src2_imm", src2, 32'h44);
    check("sel.store", ex_store_data, 32'h99);
    check("sel.alu_ctrl", 32'(alu_ctrl), 32'b1001);
    clear_fwd();

    // Load-use: load x7 in EX, consumer of x7 in ID
    set_id(1'b1, 32'h200, 32'h0, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h204, 32'h0, 32'h0, 32'h0, 5'd1, 5'd7, 5'd8, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("load_use.hazard", 32'(load_use_hazard), 32'd1);
    tick();
    #2;
    check("load_use.bubble_valid", 32'(ex_valid), 32'd0);
    check("load_use.hazard_clear", 32'(load_use_hazard), 32'd0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd7; mem_result = 32'hCAFEF00D;
    #2;
    check("load_use.consumer_valid", 32'(ex_valid), 32'd1);
    check("load_use.src2", src2, 32'hCAFEF00D);
    check("load_use.hazard_after", 32'(load_use_hazard), 32'd0);
    clear_fwd();

    // Stall captures a forwarded value before its producer retires
    set_id(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0, 5'd4, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_result = 32'h12345678;
    stall = 1'b1;
    #2;
    check("stall.src1_c0", src1, 32'h12345678);
    tick();
    wb_reg_write = 1'b0;
    #2;
    check("stall.src1_c1", src1, 32'h12345678);
    tick();
    #2;
    check("stall.src1_c2", src1, 32'h12345678);
    check("stall.valid", 32'(ex_valid), 32'd1);
    stall = 1'b0;
    clear_fwd();

    // flush together with stall: flush wins
    set_id(1'b1, 32'h400, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #2;
    check("flush.loaded", 32'(ex_valid), 32'd1);
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    #2;
    check("flush.valid", 32'(ex_valid), 32'd0);
    check("flush.alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("flush.src1", src1, 32'd0);
    check("flush.rd", 32'(ex_rd_addr), 32'd0);

    // Asynchronous reset mid-cycle
    set_id(1'b1, 32'h500, 32'h0000AAAA, 32'h5555, 32'h0, 5'd1, 5'd2, 5'd5, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    id_valid = 1'b0;
    #1;
    check("async_rst.pre_src1", src1, 32'h0000AAAA);
    rst = 1'b0;
    m = '0;
    #1;
    check("async_rst.valid", 32'(ex_valid), 32'd0);
    check("async_rst.alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("async_rst.src1", src1, 32'd0);
    check("async_rst.src2", src2, 32'd0);
    check("async_rst.rd", 32'(ex_rd_addr), 32'd0);
    check("async_rst.mem_read", 32'(ex_mem_read), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 9) != 0);
      id_pc         = $urandom();
      id_rs1_data   = $urandom();
      id_rs2_data   = $urandom();
      id_imm        = $urandom();
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rd_addr    = 5'($urandom_range(0, 7));
      id_alu_ctrl   = 4'($urandom());
      id_use_pc     = 1'($urandom());
      id_use_imm    = 1'($urandom());
      id_reg_write  = 1'($urandom());
      id_mem_read   = ($urandom_range(0, 2) == 0);
      mem_reg_write = 1'($urandom());
      mem_rd_addr   = 5'($urandom_range(0, 7));
      mem_result    = $urandom();
      wb_reg_write  = 1'($urandom());
      wb_rd_addr    = 5'($urandom_range(0, 7));
      wb_result     = $urandom();
      stall         = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      check_all($sformatf("rand[%0d]", i));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
